ysyx_22050612_dmem_resp: RTL and testbench
==========================================

YSYX_22050612_DMEM_RESP -- requirements
Module: ysyx_22050612_dmem_resp

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, giving the number of 64-bit memory words.
REQ-002 The block SHALL have parameter BASE, default 64'h8000_0000, giving the byte address of word 0.
REQ-003 The block SHALL have parameter LATENCY, default 2, giving the cycles from request acceptance to response valid; legal values are 1..15.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert and active-low.
REQ-006 The block SHALL have port req_valid, input, 1 bit: the initiator (EXU/LSU) presents a request.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-008 The block SHALL have port req_wen, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr, input, 64 bits: byte address.
REQ-010 The block SHALL have port req_wdata, input, 64 bits: write data, lane-aligned.
REQ-011 The block SHALL have port req_wmask, input, 8 bits: byte-lane write enables.
REQ-012 The block SHALL have port resp_valid, output, 1 bit: a response is present.
REQ-013 The block SHALL have port resp_ready, input, 1 bit: the initiator accepts the response.
REQ-014 The block SHALL have port resp_rdata, output, 64 bits: the full word read; 0 on writes and on errors.
REQ-015 The block SHALL have port resp_err, output, 1 bit: access fault.

Function
REQ-016 The block SHALL implement the FSM states IDLE, WAIT and RESP, with exactly one transaction outstanding.
REQ-017 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-018 On acceptance the block SHALL capture wen, addr, wdata and wmask, load the counter with LATENCY-1, and enter WAIT.
REQ-019 In WAIT the counter SHALL decrement each cycle; on the edge where the counter is 0 the block SHALL perform the access, register rdata and err, and enter RESP.
REQ-020 resp_valid SHALL be asserted on exactly the LATENCY-th rising edge after acceptance.
REQ-021 In RESP, resp_valid, resp_rdata and resp_err SHALL be held stable until resp_ready=1 is sampled, after which the block SHALL enter IDLE with resp_valid=0; a new request SHALL NOT be accepted on that same edge.
REQ-022 The word index SHALL be (req_addr - BASE) >> 3, and the address SHALL be in range if (req_addr - BASE) < DEPTH*8, compared as unsigned 64-bit with wrap-around (addresses below BASE are out of range).
REQ-023 An out-of-range access SHALL set resp_err=1 and resp_rdata=0, and a write SHALL NOT modify any word.
REQ-024 A write SHALL update only the bytes whose req_wmask bit is 1; wmask=0 SHALL be a legal no-op that returns err=0.
REQ-025 A read SHALL return the full 64-bit word, and the initiator SHALL perform any lane selection and sign extension.
REQ-026 req_valid asserted outside IDLE SHALL be ignored (not queued), and the initiator SHALL hold the request until it sees req_ready.

Reset
REQ-027 On rst_n=0 the block SHALL set state=IDLE, counter=0, resp_valid=0, resp_err=0 and resp_rdata=0, and req_ready SHALL be 1 once rst_n=1.
REQ-028 Memory array contents SHALL NOT be reset.
REQ-029 Reset in WAIT SHALL abort the transaction, and a write not yet performed SHALL NOT be committed.
REQ-030 Reset in RESP SHALL drop the response.

Configuration
REQ-031 With macro YSYX_22050612_DMEM_MISALIGN_ERR_EN defined, an accepted request with req_addr[2:0]!=0 SHALL complete with resp_err=1, resp_rdata=0 and no write.
REQ-032 Without YSYX_22050612_DMEM_MISALIGN_ERR_EN, req_addr[2:0] SHALL be ignored for word selection and no misalign error SHALL exist.

Verification
REQ-033 A bench SHALL write addr 0x80000008, wdata 0x1122334455667788, mask 0xFF, then read 0x80000008 (LATENCY=2): resp_valid 2 edges after each accept, rdata=0x1122334455667788, err=0.
REQ-034 A bench SHALL write mask 0x0F with wdata 0xAAAAAAAABBBBBBBB over the word above, then read: rdata=0x11223344BBBBBBBB.
REQ-035 A bench SHALL read 0x7FFFFFF8 and then 0x80000000+DEPTH*8: both give err=1 and rdata=0, and a subsequent read of 0x80000000 is unchanged.
REQ-036 A bench SHALL hold resp_ready=0 for 5 cycles: resp_valid stays 1 with stable data, req_ready=0 throughout, and a req_valid pulse during this time is not accepted.
REQ-037 A bench SHALL write 0xDEAD to 0x80000010, assert rst_n=0 one cycle after accept (LATENCY=3), then read: rdata equals the pre-write value, and outputs are 0 during reset.
REQ-038 A bench SHALL read 0x80000004 with YSYX_22050612_DMEM_MISALIGN_ERR_EN defined and expect err=1; with the macro undefined it SHALL expect err=0 and rdata equal to the word at 0x80000000.

Source files
------------

// File: rtl/ysyx_22050612_dmem_resp.sv
// ysyx_22050612_dmem_resp
// ------------------------------------------------------------------------
// Purpose: single-outstanding data-memory responder for an EXU/LSU
// initiator. A request is accepted in IDLE. The access itself happens
// LATENCY cycles later. The response is then held until the initiator
// takes it.
//
// Parameters:
//   DEPTH   - number of 64-bit words in the array
//   BASE    - byte address of word 0
//   LATENCY - rising edges from acceptance to resp_valid (1..15)
//
// Ports:
//   clk, rst_n                       - clock (rising edge), async active-low reset
//   req_valid / req_ready            - request handshake
//   req_wen, req_addr, req_wdata,    - request payload
//   req_wmask                          (byte-lane write enables)
//   resp_valid / resp_ready          - response handshake
//   resp_rdata, resp_err             - full read word (0 on writes/errors), fault
//
// Build option:
//   YSYX_22050612_DMEM_MISALIGN_ERR_EN - when defined, an address with
//   req_addr[2:0] != 0 completes with an error and no write. Otherwise the
//   low address bits are ignored.
// ------------------------------------------------------------------------
module ysyx_22050612_dmem_resp #(
  parameter int          DEPTH   = 1024,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] SPAN     = 64'(DEPTH) * 64'd8;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_next;
  logic [3:0] cnt;

  // Request captured at acceptance. The range/alignment check is resolved
  // then, so only the word index has to be kept.
  logic          wen_q;
  logic          err_q;
  logic [AW-1:0] idx_q;
  logic [63:0]   wdata_q;
  logic [7:0]    wmask_q;

  logic [63:0] mem [DEPTH];

  logic [63:0] offset;
  logic        in_range;
  logic        misalign;
  logic        accept;
  logic        access;
  logic [7:0]  lane_we;

  // The unsigned subtraction wraps for addresses below BASE. Those addresses
  // become huge offsets, which fail the range compare.
  assign offset   = req_addr - BASE;
  assign in_range = (offset < SPAN);

`ifdef YSYX_22050612_DMEM_MISALIGN_ERR_EN
  assign misalign = |req_addr[2:0];
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    access     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          access     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
      wen_q      <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 64'd0;
      wmask_q    <= 8'd0;
    end else begin
      state <= state_next;
      if (accept) begin
        wen_q   <= req_wen;
        err_q   <= ~in_range | misalign;
        idx_q   <= offset[AW+2:3];
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
        cnt     <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (access) begin
        resp_err   <= err_q;
        resp_rdata <= (!wen_q && !err_q) ? mem[idx_q] : 64'd0;
      end else if (state == RESP && resp_ready) begin
        // Clear the data once it has been taken, so stale data never lingers.
        resp_rdata <= 64'd0;
        resp_err   <= 1'b0;
      end
    end
  end

  // Byte-lane write enables. access is derived from the async-reset state
  // register. A reset during WAIT therefore forces it low, and the pending
  // write is never committed.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign lane_we[gi] = access & wen_q & ~err_q & wmask_q[gi];
  end

  // The array contents are never reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (lane_we[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_dmem_resp.sv
// Directed bench for ysyx_22050612_dmem_resp.
// Instance A uses LATENCY=2 and instance B uses LATENCY=3. Both receive the
// same stimulus, and `sel` picks which instance's outputs are checked.
module tb_ysyx_22050612_dmem_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wen = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic [7:0]  req_wmask = 8'd0;
  logic        resp_ready = 1'b1;

  logic        rdy_a, vld_a, err_a, rdy_b, vld_b, err_b;
  logic [63:0] rdata_a, rdata_b;

  logic        sel = 1'b0;
  logic        rdy, vld, err;
  logic [63:0] rdata;

  int tests = 0;
  int fails = 0;

  localparam logic [63:0] PRE_VAL = 64'h5555_6666_7777_8888;
  localparam logic [63:0] W0_VAL  = 64'h0123_4567_89AB_CDEF;

  always #5 clk = ~clk;

  ysyx_22050612_dmem_resp #(.DEPTH(1024), .BASE(64'h8000_0000), .LATENCY(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(rdy_a), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(vld_a), .resp_ready(resp_ready),
    .resp_rdata(rdata_a), .resp_err(err_a)
  );

  ysyx_22050612_dmem_resp #(.DEPTH(1024), .BASE(64'h8000_0000), .LATENCY(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(rdy_b), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(vld_b), .resp_ready(resp_ready),
    .resp_rdata(rdata_b), .resp_err(err_b)
  );

  assign rdy   = sel ? rdy_b   : rdy_a;
  assign vld   = sel ? vld_b   : vld_a;
  assign err   = sel ? err_b   : err_a;
  assign rdata = sel ? rdata_b : rdata_a;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction. Call it at #1 after a rising edge. It returns at #1
  // after the edge that raised resp_valid. When resp_ready is 1, it returns
  // one cycle later, after the handshake.
  task automatic send(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [7:0] mask, input logic [63:0] exp_rdata,
                      input logic exp_err, input int lat, input string tag);
    int n;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = mask;
    req_valid = 1'b1;
    n = 0;
    while (rdy !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, " ready"}, 64'(rdy), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (vld !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " rdata"}, rdata, exp_rdata);
    chk({tag, " err"}, 64'(err), 64'(exp_err));
    $display("[TB] %s wen=%0b addr=%h wdata=%h mask=%h -> lat=%0d rdata=%h err=%0b",
             tag, wen, addr, wdata, mask, n, rdata, err);
    if (resp_ready) begin
      @(posedge clk); #1;
      chk({tag, " vld drop"}, 64'(vld), 64'd0);
      chk({tag, " ready back"}, 64'(rdy), 64'd1);
    end
  endtask

  initial begin
    logic [63:0] held;

    // Power-on reset.
    repeat (3) @(posedge clk);
    #1;
    chk("reset vld", 64'(vld_a), 64'd0);
    chk("reset rdata", rdata_a, 64'd0);
    chk("reset err", 64'(err_a), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("reset ready", 64'(rdy_a), 64'd1);

    // Instance A, LATENCY=2.
    send(1'b1, 64'h8000_0000, W0_VAL, 8'hFF, 64'd0, 1'b0, 2, "wr w0");
    send(1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 1'b0, 2, "wr w1");
    send(1'b0, 64'h8000_0008, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 1'b0, 2, "rd w1");
    send(1'b1, 64'h8000_0008, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 64'd0, 1'b0, 2, "wr w1 m0F");
    send(1'b0, 64'h8000_0008, 64'd0, 8'h00, 64'h1122_3344_BBBB_BBBB, 1'b0, 2, "rd w1 merged");
    send(1'b1, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'd0, 1'b0, 2, "wr mask0");
    send(1'b0, 64'h8000_0008, 64'd0, 8'h00, 64'h1122_3344_BBBB_BBBB, 1'b0, 2, "rd after mask0");
    send(1'b1, 64'h8000_1FF8, 64'hCAFE_F00D_0000_1234, 8'hFF, 64'd0, 1'b0, 2, "wr last");
    send(1'b0, 64'h8000_1FF8, 64'd0, 8'h00, 64'hCAFE_F00D_0000_1234, 1'b0, 2, "rd last");
    send(1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 64'd0, 1'b1, 2, "rd below base");
    send(1'b0, 64'h8000_2000, 64'd0, 8'h00, 64'd0, 1'b1, 2, "rd past end");
    send(1'b1, 64'h8000_2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 64'd0, 1'b1, 2, "wr past end");
    send(1'b0, 64'h8000_0000, 64'd0, 8'h00, W0_VAL, 1'b0, 2, "rd w0 intact");
`ifdef YSYX_22050612_DMEM_MISALIGN_ERR_EN
    send(1'b0, 64'h8000_0004, 64'd0, 8'h00, 64'd0, 1'b1, 2, "rd misaligned");
`else
    send(1'b0, 64'h8000_0004, 64'd0, 8'h00, W0_VAL, 1'b0, 2, "rd misaligned");
`endif

    // Back-pressure: the response is held, and a request pulse is ignored.
    resp_ready = 1'b0;
    send(1'b0, 64'h8000_0008, 64'd0, 8'h00, 64'h1122_3344_BBBB_BBBB, 1'b0, 2, "rd stall");
    held = rdata;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        req_wen = 1'b1; req_addr = 64'h8000_0008; req_wdata = 64'd0;
        req_wmask = 8'hFF; req_valid = 1'b1;
      end
      if (i == 2) req_valid = 1'b0;
      chk($sformatf("stall vld %0d", i), 64'(vld), 64'd1);
      chk($sformatf("stall rdata %0d", i), rdata, held);
      chk($sformatf("stall ready %0d", i), 64'(rdy), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall release vld", 64'(vld), 64'd0);
    chk("stall release ready", 64'(rdy), 64'd1);
    send(1'b0, 64'h8000_0008, 64'd0, 8'h00, 64'h1122_3344_BBBB_BBBB, 1'b0, 2, "rd after stall");

    // Instance B, LATENCY=3. Start both instances from a clean reset.
    sel = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("b ready after reset", 64'(rdy), 64'd1);
    send(1'b1, 64'h8000_0010, PRE_VAL, 8'hFF, 64'd0, 1'b0, 3, "b wr pre");

    // Reset while the response is pending drops it.
    resp_ready = 1'b0;
    send(1'b0, 64'h8000_0010, 64'd0, 8'h00, PRE_VAL, 1'b0, 3, "b rd pre");
    rst_n = 1'b0;
    #1;
    chk("b resp rst vld", 64'(vld), 64'd0);
    chk("b resp rst rdata", rdata, 64'd0);
    chk("b resp rst err", 64'(err), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    resp_ready = 1'b1;
    #1;
    chk("b resp rst ready", 64'(rdy), 64'd1);

    // Reset one cycle after a write is accepted aborts that write.
    req_wen = 1'b1; req_addr = 64'h8000_0010; req_wdata = 64'h0000_0000_0000_DEAD;
    req_wmask = 8'hFF; req_valid = 1'b1;
    chk("b abort accept ready", 64'(rdy), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    $display("[TB] b abort wr addr=%h wdata=%h accepted, reset follows", req_addr, req_wdata);
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("b abort rst vld %0d", i), 64'(vld), 64'd0);
      chk($sformatf("b abort rst rdata %0d", i), rdata, 64'd0);
      chk($sformatf("b abort rst err %0d", i), 64'(err), 64'd0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    #1;
    chk("b abort ready", 64'(rdy), 64'd1);
    send(1'b0, 64'h8000_0010, 64'd0, 8'h00, PRE_VAL, 1'b0, 3, "b rd after abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
